exmem_memwb_pipe: RTL and testbench
===================================

Name: exmem_memwb_pipe

Overview:
- Producer side of the operand-forwarding interface. Holds the EX/MEM (x_m) and MEM/WB (m_w) pipeline registers that drive the forwarding unit: destination register, regwrite, r15write and the result values.
- Also drives the memory-access request/acknowledge handshake.
- Raises the stall and bubble controls the forwarding unit cannot resolve:
  - a load-use hazard, because an x_m load has no data until MEM completes;
  - a multi-cycle memory wait.
- Sits between the EX stage and the register-file write port.

Parameters:
DW, 16, datapath width of ALU result, store data and load data
RW, 4, register address width; register 0 is never a write destination; register 2^RW-1 is r15

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
d_xop1  input  RW  source register 1 of the instruction in EX
d_xop2  input  RW  source register 2 of the instruction in EX
d_xdst  input  RW  destination register of the instruction in EX
d_xregwrite  input  1  EX instruction writes d_xdst
d_xr15write  input  1  EX instruction writes r15 (link/branch)
d_xmemread  input  1  EX instruction is a load
d_xmemwrite  input  1  EX instruction is a store
d_xvalid  input  1  EX holds a real instruction; 0 means bubble
alu_res  input  DW  EX result (load/store: effective address)
st_data  input  DW  store data
mem_req  output  1  memory request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  DW  memory address
mem_wdata  output  DW  memory write data
mem_ack  input  1  memory done; read data valid this cycle
mem_rdata  input  DW  load data
x_mop2  output  RW  x_m destination register
x_mregwrite  output  1  x_m writes a register
x_mr15write  output  1  x_m writes r15
x_mres  output  DW  x_m ALU result, forwarding source 100
m_wop2  output  RW  m_w destination register
m_wregwrite  output  1  m_w writes a register (also the register-file write enable)
m_wr15write  output  1  m_w writes r15
m_wres  output  DW  m_w write-back value, forwarding source 011
stall  output  1  freeze PC, IF/ID and ID/EX this cycle
ex_bubble  output  1  EX contents are not to advance (load-use)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all x_m and m_w fields cleared;
  - mem_req=0; mem_we, mem_addr, mem_wdata = 0;
  - stall=0; ex_bubble=0;
  - FSM in IDLE.
- Each register-write qualifier is forced to 0 when its destination is 0; r15write is unaffected.
- FSM states:
  - IDLE: x_m holds no memory instruction.
  - ACCESS: mem_req=1, waiting for mem_ack.
- Load-use detection (combinational):
  - luse = x_m is a load AND x_mregwrite AND x_mop2≠0 AND (x_mop2==d_xop1 OR x_mop2==d_xop2) AND d_xvalid.
  - When luse, x_mregwrite is presented to the forwarding unit as 0; x_mop2 is masked, since the ALU result is an address, not data.
- Advance rule, per clock with no stall:
  - x_m <= EX fields, qualified by d_xvalid;
  - m_w <= x_m fields; m_wres = x_mres for ALU ops, mem_rdata for loads.
- Memory access:
  - When an instruction with memread/memwrite enters x_m, the FSM goes IDLE->ACCESS the same edge. mem_req is registered high that edge; mem_addr=alu_res, mem_we=memwrite, mem_wdata=st_data, all held stable.
  - In ACCESS with mem_ack=0: stall=1, x_m holds, and m_w receives a bubble (m_wregwrite=0, m_wr15write=0).
  - In ACCESS with mem_ack=1: m_w captures the x_m fields (load: m_wres=mem_rdata) and x_m takes the EX fields. mem_req drops next cycle unless the new x_m is also a memory op, in which case the FSM stays in ACCESS with the new address.
  - Minimum memory latency: 1 cycle (mem_ack in the first mem_req cycle).
- Load-use stall:
  - luse → stall=1 and ex_bubble=1 for exactly one cycle.
  - x_m advances normally; a bubble is inserted behind it.
  - The stalled EX instruction is re-evaluated next cycle against m_w (forwarding source 011).
- Simultaneous load-use and ACCESS wait: stall stays 1 until mem_ack. ex_bubble follows luse and is re-evaluated each cycle.
- Store as producer: a store sets no regwrite, so no forwarding is generated from it.
- Reset mid-ACCESS: mem_req drops asynchronously and the pending access is abandoned. The memory side must ignore a late mem_ack while rst_n=0.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams DW and RW, and R15 = 2^RW-1;
  - forwarding-select encodings FWD_NONE=000, FWD_R15_MW=001, FWD_R15_XM=010, FWD_MW=011, FWD_XM=100;
  - FSM state enum {IDLE, ACCESS}.
- One natural sub-module, mem_access_fsm: owns the mem_req/mem_ack handshake and produces mem_stall. It is instantiated inside exmem_memwb_pipe.

Test Plan:
- ALU chain: ADD r3 in EX with d_xvalid=1 -> next cycle x_mop2=3, x_mregwrite=1, x_mres=alu_res; cycle after: m_wop2=3, m_wres equals that value, stall=0 throughout.
- Load-use: LD r5 in x_m, EX reads d_xop2=5 -> stall=1, ex_bubble=1 one cycle, x_mregwrite presented 0; next cycle m_wop2=5, m_wres=mem_rdata (0xBEEF), stall=0.
- Memory wait: load in x_m, mem_ack delayed 3 cycles -> mem_req=1 and stall=1 for 3 cycles, mem_addr stable, m_wregwrite=0 during wait; on ack m_wres=mem_rdata.
- Back-to-back stores at 0x0010 then 0x0020, both 1-cycle ack -> mem_req stays 1 across both, mem_addr steps 0x0010→0x0020, no regwrite on m_w.
- Destination r0: ADD writing r0 -> x_mregwrite=0 and m_wregwrite=0; branch with d_xr15write=1 -> x_mr15write=1 then m_wr15write=1.
- Async reset asserted mid-ACCESS -> mem_req, stall, x_mregwrite and m_wregwrite go 0 without a clock edge; after release, FSM is IDLE and the first new instruction flows normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM and MEM/WB pipeline slice: widths,
// forwarding-select encodings and the memory-access FSM state type.
package pipe_pkg;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam logic [RW-1:0] R15 = {RW{1'b1}};

  localparam logic [2:0] FWD_NONE   = 3'b000;
  localparam logic [2:0] FWD_R15_MW = 3'b001;
  localparam logic [2:0] FWD_R15_XM = 3'b010;
  localparam logic [2:0] FWD_MW     = 3'b011;
  localparam logic [2:0] FWD_XM     = 3'b100;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Memory request/acknowledge handshake for the instruction held in x_m.
// The request is registered on the edge a memory instruction enters x_m.
module mem_access_fsm
  import pipe_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         start_we,
  input  logic [W-1:0] start_addr,
  input  logic [W-1:0] start_wdata,
  input  logic         mem_ack,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_stall
);

  mem_state_e   state_r;
  mem_state_e   state_s;
  logic         req_r;
  logic         we_r;
  logic [W-1:0] addr_r;
  logic [W-1:0] wdata_r;

  // next-state: an unacknowledged access holds, otherwise a new memory op re-arms
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (!mem_ack) begin
          state_s = ACCESS;
        end else if (start) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // request register; address and data stay put for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {W{1'b0}};
      wdata_r <= {W{1'b0}};
    end else begin
      req_r <= (state_s == ACCESS);
      if (start) begin
        we_r    <= start_we;
        addr_r  <= start_addr;
        wdata_r <= start_wdata;
      end else begin
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign mem_req   = req_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_stall = (state_r == ACCESS) && !mem_ack;

endmodule

// File: rtl/exmem_memwb_pipe.sv
// EX/MEM (x_m) and MEM/WB (m_w) pipeline registers feeding the forwarding unit,
// with load-use and memory-wait stall generation.
module exmem_memwb_pipe #(
  parameter int DW = pipe_pkg::DW,
  parameter int RW = pipe_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] d_xop1,
  input  logic [RW-1:0] d_xop2,
  input  logic [RW-1:0] d_xdst,
  input  logic          d_xregwrite,
  input  logic          d_xr15write,
  input  logic          d_xmemread,
  input  logic          d_xmemwrite,
  input  logic          d_xvalid,
  input  logic [DW-1:0] alu_res,
  input  logic [DW-1:0] st_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [RW-1:0] x_mop2,
  output logic          x_mregwrite,
  output logic          x_mr15write,
  output logic [DW-1:0] x_mres,
  output logic [RW-1:0] m_wop2,
  output logic          m_wregwrite,
  output logic          m_wr15write,
  output logic [DW-1:0] m_wres,
  output logic          stall,
  output logic          ex_bubble
);

  localparam logic [RW-1:0] REG_ZERO = {RW{1'b0}};

  logic [RW-1:0] xm_dst_r;
  logic          xm_rw_r;
  logic          xm_r15_r;
  logic          xm_ld_r;
  logic [DW-1:0] xm_res_r;

  logic [RW-1:0] mw_dst_r;
  logic          mw_rw_r;
  logic          mw_r15_r;
  logic [DW-1:0] mw_res_r;

  logic          ex_rw_s;
  logic          luse_s;
  logic          mem_stall_s;
  logic          stall_s;
  logic          start_s;

  // hazard detection; r0 is never a real write destination
  always_comb begin
    ex_rw_s = d_xregwrite && (d_xdst != REG_ZERO);
    luse_s  = xm_ld_r && xm_rw_r && (xm_dst_r != REG_ZERO) &&
              ((xm_dst_r == d_xop1) || (xm_dst_r == d_xop2)) && d_xvalid;
    stall_s = mem_stall_s || luse_s;
    start_s = !stall_s && d_xvalid && (d_xmemread || d_xmemwrite);
  end

  mem_access_fsm #(
    .W (DW)
  ) u_mem_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .start_we    (d_xmemwrite),
    .start_addr  (alu_res),
    .start_wdata (st_data),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_stall   (mem_stall_s)
  );

  // x_m: holds during a memory wait, takes a bubble behind a load-use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xm_dst_r <= REG_ZERO;
      xm_rw_r  <= 1'b0;
      xm_r15_r <= 1'b0;
      xm_ld_r  <= 1'b0;
      xm_res_r <= {DW{1'b0}};
    end else if (mem_stall_s) begin
      xm_dst_r <= xm_dst_r;
      xm_rw_r  <= xm_rw_r;
      xm_r15_r <= xm_r15_r;
      xm_ld_r  <= xm_ld_r;
      xm_res_r <= xm_res_r;
    end else if (luse_s || !d_xvalid) begin
      xm_dst_r <= REG_ZERO;
      xm_rw_r  <= 1'b0;
      xm_r15_r <= 1'b0;
      xm_ld_r  <= 1'b0;
      xm_res_r <= {DW{1'b0}};
    end else begin
      xm_dst_r <= d_xdst;
      xm_rw_r  <= ex_rw_s;
      xm_r15_r <= d_xr15write;
      xm_ld_r  <= d_xmemread;
      xm_res_r <= alu_res;
    end
  end

  // m_w: bubble while memory is outstanding, loads write back the returned data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw_dst_r <= REG_ZERO;
      mw_rw_r  <= 1'b0;
      mw_r15_r <= 1'b0;
      mw_res_r <= {DW{1'b0}};
    end else if (mem_stall_s) begin
      mw_dst_r <= REG_ZERO;
      mw_rw_r  <= 1'b0;
      mw_r15_r <= 1'b0;
      mw_res_r <= {DW{1'b0}};
    end else begin
      mw_dst_r <= xm_dst_r;
      mw_rw_r  <= xm_rw_r;
      mw_r15_r <= xm_r15_r;
      mw_res_r <= xm_ld_r ? mem_rdata : xm_res_r;
    end
  end

  // an x_m load under load-use carries an address, so it must not be forwarded
  assign x_mop2      = luse_s ? REG_ZERO : xm_dst_r;
  assign x_mregwrite = xm_rw_r && !luse_s;
  assign x_mr15write = xm_r15_r;
  assign x_mres      = xm_res_r;

  assign m_wop2      = mw_dst_r;
  assign m_wregwrite = mw_rw_r;
  assign m_wr15write = mw_r15_r;
  assign m_wres      = mw_res_r;

  assign stall       = stall_s;
  assign ex_bubble   = luse_s;

endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// Self-checking bench for exmem_memwb_pipe: directed scenarios with literal
// expectations, then randomized traffic against an instruction-slot model.
module tb_exmem_memwb_pipe;

  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] d_xop1, d_xop2, d_xdst;
  logic          d_xregwrite, d_xr15write, d_xmemread, d_xmemwrite, d_xvalid;
  logic [DW-1:0] alu_res, st_data;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [RW-1:0] x_mop2, m_wop2;
  logic          x_mregwrite, x_mr15write, m_wregwrite, m_wr15write;
  logic [DW-1:0] x_mres, m_wres;
  logic          stall, ex_bubble;

  always #5 clk = ~clk;

  exmem_memwb_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_xop1(d_xop1), .d_xop2(d_xop2), .d_xdst(d_xdst),
    .d_xregwrite(d_xregwrite), .d_xr15write(d_xr15write),
    .d_xmemread(d_xmemread), .d_xmemwrite(d_xmemwrite), .d_xvalid(d_xvalid),
    .alu_res(alu_res), .st_data(st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .x_mop2(x_mop2), .x_mregwrite(x_mregwrite), .x_mr15write(x_mr15write), .x_mres(x_mres),
    .m_wop2(m_wop2), .m_wregwrite(m_wregwrite), .m_wr15write(m_wr15write), .m_wres(m_wres),
    .stall(stall), .ex_bubble(ex_bubble)
  );

  // One pipeline slot of the reference model: an instruction, or an empty slot.
  typedef struct {
    logic [RW-1:0] dst;
    bit            rw;
    bit            r15;
    bit            ld;
    bit            st;
    logic [DW-1:0] res;
    logic [DW-1:0] wd;
  } slot_t;

  slot_t xm, mw;
  int    errors = 0;
  int    checks = 0;
  bit    last_stall = 1'b0;
  int    wait_cnt = 0;

  function automatic slot_t empty_slot();
    slot_t s;
    s.dst = '0; s.rw = 1'b0; s.r15 = 1'b0; s.ld = 1'b0; s.st = 1'b0;
    s.res = '0; s.wd = '0;
    return s;
  endfunction

  function automatic bit is_mem(input slot_t s);
    return s.ld || s.st;
  endfunction

  // A load in x_m whose destination is read by a real EX instruction.
  function automatic bit model_luse();
    return xm.ld && xm.rw && (xm.dst != '0) &&
           ((xm.dst == d_xop1) || (xm.dst == d_xop2)) && d_xvalid;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with what the model says it must be right now.
  task automatic compare();
    bit luse_e, wait_e;
    luse_e = model_luse();
    wait_e = is_mem(xm) && !mem_ack;
    chk("stall",       32'(stall),       32'(wait_e || luse_e));
    chk("ex_bubble",   32'(ex_bubble),   32'(luse_e));
    chk("x_mop2",      32'(x_mop2),      luse_e ? 32'd0 : 32'(xm.dst));
    chk("x_mregwrite", 32'(x_mregwrite), 32'(xm.rw && !luse_e));
    chk("x_mr15write", 32'(x_mr15write), 32'(xm.r15));
    chk("x_mres",      32'(x_mres),      32'(xm.res));
    chk("m_wop2",      32'(m_wop2),      32'(mw.dst));
    chk("m_wregwrite", 32'(m_wregwrite), 32'(mw.rw));
    chk("m_wr15write", 32'(m_wr15write), 32'(mw.r15));
    chk("m_wres",      32'(m_wres),      32'(mw.res));
    chk("mem_req",     32'(mem_req),     32'(is_mem(xm)));
    if (is_mem(xm)) begin
      chk("mem_we",    32'(mem_we),    32'(xm.st));
      chk("mem_addr",  32'(mem_addr),  32'(xm.res));
      chk("mem_wdata", 32'(mem_wdata), 32'(xm.wd));
    end
    last_stall = wait_e || luse_e;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit luse_e, wait_e;
    luse_e = model_luse();
    wait_e = is_mem(xm) && !mem_ack;
    if (wait_e) begin
      mw = empty_slot();
    end else begin
      mw = xm;
      if (xm.ld) mw.res = mem_rdata;
      if (luse_e || !d_xvalid) begin
        xm = empty_slot();
      end else begin
        xm.dst = d_xdst;
        xm.rw  = d_xregwrite && (d_xdst != '0);
        xm.r15 = d_xr15write;
        xm.ld  = d_xmemread;
        xm.st  = d_xmemwrite;
        xm.res = alu_res;
        xm.wd  = st_data;
      end
    end
  endtask

  task automatic set_ex(input bit v, input logic [RW-1:0] dst, input logic [RW-1:0] op1,
                        input logic [RW-1:0] op2, input bit rw, input bit r15, input bit ld,
                        input bit st, input logic [DW-1:0] res, input logic [DW-1:0] wd);
    d_xvalid = v; d_xdst = dst; d_xop1 = op1; d_xop2 = op2;
    d_xregwrite = rw; d_xr15write = r15; d_xmemread = ld; d_xmemwrite = st;
    alu_res = res; st_data = wd;
  endtask

  task automatic nop();
    set_ex(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nop(); mem_ack = 1'b0; cyc();
    end
  endtask

  task automatic rand_ex();
    int kind;
    bit v, rw, r15, ld, st;
    kind = $urandom_range(0, 9);
    v = (kind != 0); rw = 1'b0; r15 = 1'b0; ld = 1'b0; st = 1'b0;
    case (kind)
      0: begin
        rw = ($urandom_range(0, 1) == 1); r15 = ($urandom_range(0, 1) == 1);
        ld = ($urandom_range(0, 1) == 1); st = !ld && ($urandom_range(0, 1) == 1);
      end
      1, 2, 3, 4: rw = 1'b1;
      5, 6: begin rw = 1'b1; ld = 1'b1; end
      7: st = 1'b1;
      8: begin r15 = 1'b1; rw = ($urandom_range(0, 1) == 1); end
      default: rw = 1'b0;
    endcase
    set_ex(v, RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
           rw, r15, ld, st, DW'($urandom), DW'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; nop(); mem_ack = 1'b0; mem_rdata = 16'h0000;
    xm = empty_slot(); mw = empty_slot();
    @(negedge clk); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ex_bubble", 32'(ex_bubble), 32'd0);
    chk("rst_x_mregwrite", 32'(x_mregwrite), 32'd0);
    chk("rst_x_mres", 32'(x_mres), 32'd0);
    chk("rst_m_wregwrite", 32'(m_wregwrite), 32'd0);
    chk("rst_m_wres", 32'(m_wres), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU chain: ADD r3
    set_ex(1'b1, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000); cyc();
    nop(); settle();
    chk("alu_x_mop2", 32'(x_mop2), 32'd3);
    chk("alu_x_mregwrite", 32'(x_mregwrite), 32'd1);
    chk("alu_x_mres", 32'(x_mres), 32'h1234);
    advance();
    nop(); settle();
    chk("alu_m_wop2", 32'(m_wop2), 32'd3);
    chk("alu_m_wres", 32'(m_wres), 32'h1234);
    chk("alu_stall", 32'(stall), 32'd0);
    advance();
    idle(2);

    // Load-use: LD r5 then ADD reading r5
    set_ex(1'b1, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000); cyc();
    set_ex(1'b1, 4'd6, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF; settle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_ex_bubble", 32'(ex_bubble), 32'd1);
    chk("lu_x_mregwrite", 32'(x_mregwrite), 32'd0);
    chk("lu_mem_addr", 32'(mem_addr), 32'h0040);
    advance();
    mem_ack = 1'b0; mem_rdata = 16'h0000; settle();
    chk("lu_m_wop2", 32'(m_wop2), 32'd5);
    chk("lu_m_wres", 32'(m_wres), 32'hBEEF);
    chk("lu_stall_after", 32'(stall), 32'd0);
    chk("lu_bubble_after", 32'(ex_bubble), 32'd0);
    advance();
    idle(2);

    // Memory wait: load acknowledged after three waiting cycles
    set_ex(1'b1, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000); cyc();
    nop();
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b0; settle();
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_mem_addr", 32'(mem_addr), 32'h0080);
      chk("wait_m_wregwrite", 32'(m_wregwrite), 32'd0);
      advance();
    end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A; settle();
    chk("wait_ack_stall", 32'(stall), 32'd0);
    advance();
    mem_ack = 1'b0; settle();
    chk("wait_m_wop2", 32'(m_wop2), 32'd7);
    chk("wait_m_wres", 32'(m_wres), 32'h5A5A);
    chk("wait_m_wregwrite_ack", 32'(m_wregwrite), 32'd1);
    advance();
    idle(2);

    // Back-to-back stores
    set_ex(1'b1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h1111); cyc();
    set_ex(1'b1, 4'd0, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h2222);
    mem_ack = 1'b1; settle();
    chk("st1_mem_req", 32'(mem_req), 32'd1);
    chk("st1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("st1_mem_we", 32'(mem_we), 32'd1);
    chk("st1_mem_wdata", 32'(mem_wdata), 32'h1111);
    advance();
    nop(); mem_ack = 1'b1; settle();
    chk("st2_mem_req", 32'(mem_req), 32'd1);
    chk("st2_mem_addr", 32'(mem_addr), 32'h0020);
    chk("st2_mem_wdata", 32'(mem_wdata), 32'h2222);
    chk("st2_m_wregwrite", 32'(m_wregwrite), 32'd0);
    advance();
    mem_ack = 1'b0; settle();
    chk("st_done_mem_req", 32'(mem_req), 32'd0);
    advance();
    idle(2);

    // Destination r0 and r15 link write
    set_ex(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0099, 16'h0000); cyc();
    set_ex(1'b1, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000); settle();
    chk("r0_x_mregwrite", 32'(x_mregwrite), 32'd0);
    advance();
    nop(); settle();
    chk("r0_m_wregwrite", 32'(m_wregwrite), 32'd0);
    chk("br_x_mr15write", 32'(x_mr15write), 32'd1);
    advance();
    nop(); settle();
    chk("br_m_wr15write", 32'(m_wr15write), 32'd1);
    advance();
    idle(2);

    // Asynchronous reset in the middle of a memory wait
    set_ex(1'b1, 4'd9, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0033, 16'h0000); cyc();
    set_ex(1'b1, 4'd4, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000); cyc();
    nop(); mem_ack = 1'b0; settle();
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    chk("mid_m_wregwrite", 32'(m_wregwrite), 32'd1);
    rst_n = 1'b0; #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_x_mregwrite", 32'(x_mregwrite), 32'd0);
    chk("arst_m_wregwrite", 32'(m_wregwrite), 32'd0);
    xm = empty_slot(); mw = empty_slot();
    mem_ack = 1'b1;
    @(negedge clk); #2;
    chk("arst_late_ack_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1; mem_ack = 1'b0;
    set_ex(1'b1, 4'd2, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0777, 16'h0000); cyc();
    nop(); settle();
    chk("post_rst_x_mop2", 32'(x_mop2), 32'd2);
    chk("post_rst_x_mres", 32'(x_mres), 32'h0777);
    advance();
    idle(1);

    // Randomized traffic; EX is frozen whenever the previous cycle stalled
    for (int n = 0; n < 800; n++) begin
      if (!last_stall) rand_ex();
      mem_rdata = DW'($urandom);
      if (is_mem(xm)) begin
        mem_ack = (wait_cnt >= 4) || ($urandom_range(0, 2) == 0);
        if (mem_ack) wait_cnt = 0;
        else wait_cnt++;
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
